crack_core_scheduler: RTL and testbench
=======================================

// Module: crack_core_scheduler
// PURPOSE
// Distributes the RC4 key search space across NUM_CORES parallel cracker cores. Each core
// sequences decrypt+check for one chunk of keys. The scheduler sits between the top-level
// Crack_Start/LEDR controls and the core array. It hands out chunks round-robin, stops all
// cores when any core reports a valid key, and reports failure when the space is exhausted.
// PARAMETERS
// NUM_CORES     4          number of cracker cores (2..8)
// BEGIN_SEARCH  22'd0      first key searched (key = {2'b00, 22-bit value})
// END_SEARCH    22'h3FFFFF last key searched, inclusive; BEGIN_SEARCH <= END_SEARCH
// CHUNK_SIZE    22'd4096   keys per dispatched chunk; must be >= 1
// PORTS
// clk            in   1            system clock
// rst            in   1            synchronous, active-high reset
// Crack_Start    in   1            1-cycle pulse; starts a search from IDLE, FOUND or FAIL
// Core_Req       in   NUM_CORES    core i is idle and requests a chunk (level)
// Core_Found     in   NUM_CORES    core i found a valid key (1-cycle pulse)
// Core_Key       in   NUM_CORES*24 key reported by core i; slice i = [24*i +: 24]
// Core_Grant     out  NUM_CORES    one-hot; the chunk below is given to core i this cycle
// Chunk_Base     out  24           first key of granted chunk
// Chunk_Last     out  24           last key of granted chunk, inclusive
// Core_Abort     out  1            all cores stop and return to idle (level while FOUND)
// Secret_Key     out  24           winning key, held until the next start or reset
// Valid_Key_Found out 1            1 in FOUND
// LEDR           out  2            2'b00 idle/running, 2'b01 found, 2'b10 fail
// BEHAVIOUR
// - Reset: state=IDLE, all outputs 0, next_base=BEGIN_SEARCH. rst mid-search resets the same way.
//   Cores see Core_Grant=0; the integrator resets them on the same rst.
// - States: IDLE -> DISPATCH on Crack_Start. DISPATCH -> DRAIN when next_base > END_SEARCH.
//   DISPATCH/DRAIN -> FOUND on any Core_Found. DRAIN -> FAIL when Core_Req is all-ones,
//   i.e. all cores are idle. FOUND/FAIL -> DISPATCH on Crack_Start. Crack_Start is ignored
//   in DISPATCH and DRAIN.
// - On start: next_base = BEGIN_SEARCH; Secret_Key, Valid_Key_Found and LEDR are cleared.
// - next_base is 23 bits wide so it cannot wrap past 22'h3FFFFF.
// - Dispatch happens in DISPATCH only. When any Core_Req is set, exactly one Core_Grant is
//   raised for 1 cycle, registered, using round-robin priority starting after the last
//   granted core.
//   Chunk_Base = next_base and Chunk_Last = min(next_base+CHUNK_SIZE-1, END_SEARCH), both
//   zero-extended to 24 bits. next_base += CHUNK_SIZE on the same edge.
//   A core must drop Core_Req the cycle after its grant.
// - Grant throughput is at most 1 per cycle. Grant latency from a Core_Req rise is 1 cycle,
//   plus the round-robin wait.
// - Found: Secret_Key <= Core_Key slice of the lowest-indexed asserted Core_Found. Then
//   Valid_Key_Found=1, LEDR=2'b01, Core_Abort=1.
//   Found beats grant in the same cycle: no grant is issued.
//   Core_Found is ignored in IDLE, FOUND and FAIL.
// - Fail: LEDR=2'b10, Valid_Key_Found=0, Secret_Key=0.
// - Chunk_Base and Chunk_Last are 0 whenever Core_Grant is 0.
// STRUCTURE
// - crack_pkg: sched_state_t enum {IDLE, DISPATCH, DRAIN, FOUND, FAIL}; KEY_W=24;
//   SEARCH_W=22; LEDR_FOUND/LEDR_FAIL constants.
// - Sub-module rr_arbiter #(N): req[N], advance, grant one-hot[N]. Its pointer advances
//   only on an issued grant.
// - Top holds the FSM, the next_base counter, the chunk clip and the found priority encoder.
// TESTING (NUM_CORES=2, BEGIN=0, END=9, CHUNK=4 unless stated)
// 1 Both cores req, start, never found -> grants core0 [0..3], core1 [4..7], core0 [8..9]
//   (clipped); then all idle -> FAIL, LEDR=2'b10.
// 2 Core1 pulses Core_Found with key 24'h000006 during DISPATCH -> Secret_Key=24'h000006,
//   Valid_Key_Found=1, LEDR=2'b01, Core_Abort=1, no further grants.
// 3 Core0 and core1 found in the same cycle with keys 2 and 5 -> Secret_Key=2.
//   A found in the same cycle as a pending req -> no grant issued.
// 4 Found in FOUND, then Crack_Start -> outputs cleared; the first grant gives Chunk_Base=0.
//   Crack_Start pulsed in DISPATCH -> ignored, next_base unchanged.
// 5 rst asserted mid-DISPATCH -> next cycle IDLE, all outputs 0. Crack_Start restarts
//   from BEGIN.
// 6 BEGIN=END=22'h3FFFFF, CHUNK=4 -> a single grant [3FFFFF..3FFFFF], then DRAIN.
//   No wrap to 0.

Source files
------------

// File: rtl/crack_pkg.sv
// Shared types and constants for the RC4 key-search scheduler and its arbiter.
package crack_pkg;

  localparam int KEY_W    = 24;
  localparam int SEARCH_W = 22;
  localparam int BASE_W   = SEARCH_W + 1;

  localparam logic [1:0] LEDR_IDLE  = 2'b00;
  localparam logic [1:0] LEDR_FOUND = 2'b01;
  localparam logic [1:0] LEDR_FAIL  = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DISPATCH = 3'd1,
    DRAIN    = 3'd2,
    FOUND    = 3'd3,
    FAIL     = 3'd4
  } sched_state_t;

  // Last key of a chunk, clipped to the end of the search space.
  function automatic logic [KEY_W-1:0] clip_last(
    input logic [BASE_W-1:0]   base,
    input logic [SEARCH_W-1:0] chunk,
    input logic [SEARCH_W-1:0] last_key
  );
    logic [KEY_W-1:0] span_end;
    span_end = {1'b0, base} + {2'b00, chunk} - 24'd1;
    if (span_end > {2'b00, last_key}) begin
      return {2'b00, last_key};
    end else begin
      return span_end;
    end
  endfunction

endpackage

// File: rtl/crack_core_scheduler_rr_arbiter.sv
// Round-robin arbiter: priority starts at the requester after the last winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW+1:0] N_W = (PW+2)'(N);
  localparam logic [N-1:0]  ONE = {{(N-1){1'b0}}, 1'b1};

  logic [PW-1:0] last;
  logic [PW:0]   shift;
  logic [N-1:0]  rotated;
  logic [PW:0]   offset;
  logic [PW+1:0] sum;
  logic [PW-1:0] winner;
  logic          hit;

  // Rotate requests so the core after the last winner sits at bit 0, then take the lowest.
  always_comb begin
    shift   = {1'b0, last} + {{PW{1'b0}}, 1'b1};
    rotated = N'({req, req} >> shift);
    offset  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      offset = rotated[i] ? (PW+1)'(i) : offset;
    end
    hit = |rotated;
    sum = {2'b00, last} + {1'b0, offset} + (PW+2)'(1);
    if (sum >= N_W) begin
      sum = sum - N_W;
    end else begin
      sum = sum;
    end
    winner = sum[PW-1:0];
    grant  = hit ? (ONE << winner) : '0;
  end

  // Pointer moves only when the top actually issues the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PW'(N - 1);
    end else if (advance && hit) begin
      last <= winner;
    end else begin
      last <= last;
    end
  end

endmodule

// File: rtl/crack_core_scheduler.sv
// Hands out RC4 key chunks round-robin to NUM_CORES crackers, latches the first
// reported key, and signals failure once the space is exhausted and all cores idle.
module crack_core_scheduler
  import crack_pkg::*;
#(
  parameter int                  NUM_CORES    = 4,
  parameter logic [SEARCH_W-1:0] BEGIN_SEARCH = 22'd0,
  parameter logic [SEARCH_W-1:0] END_SEARCH   = 22'h3FFFFF,
  parameter logic [SEARCH_W-1:0] CHUNK_SIZE   = 22'd4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Crack_Start,
  input  logic [NUM_CORES-1:0]       Core_Req,
  input  logic [NUM_CORES-1:0]       Core_Found,
  input  logic [NUM_CORES*KEY_W-1:0] Core_Key,
  output logic [NUM_CORES-1:0]       Core_Grant,
  output logic [KEY_W-1:0]           Chunk_Base,
  output logic [KEY_W-1:0]           Chunk_Last,
  output logic                       Core_Abort,
  output logic [KEY_W-1:0]           Secret_Key,
  output logic                       Valid_Key_Found,
  output logic [1:0]                 LEDR
);

  sched_state_t         state, state_nx;
  logic [BASE_W-1:0]    next_base, base_nx;
  logic [NUM_CORES-1:0] arb_req, arb_grant, grant_nx;
  logic [KEY_W-1:0]     chunk_base_nx, chunk_last_nx, key_nx, found_key;
  logic                 abort_nx, vkf_nx, issue, any_found, exhausted;
  logic [1:0]           ledr_nx;

  // A core still sees its grant this cycle, so it cannot be granted again until it drops Core_Req.
  assign arb_req = Core_Req & ~Core_Grant;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (issue),
    .grant   (arb_grant)
  );

  // Lowest-indexed reporting core wins.
  always_comb begin
    found_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      found_key = Core_Found[i] ? Core_Key[KEY_W*i +: KEY_W] : found_key;
    end
  end

  // Next-state and next-output logic; found always beats a pending grant.
  always_comb begin
    state_nx      = state;
    base_nx       = next_base;
    grant_nx      = '0;
    chunk_base_nx = '0;
    chunk_last_nx = '0;
    abort_nx      = Core_Abort;
    key_nx        = Secret_Key;
    vkf_nx        = Valid_Key_Found;
    ledr_nx       = LEDR;
    issue         = 1'b0;
    any_found     = |Core_Found;
    exhausted     = next_base > {1'b0, END_SEARCH};
    case (state)
      IDLE, FOUND, FAIL: begin
        if (Crack_Start) begin
          state_nx = DISPATCH;
          base_nx  = {1'b0, BEGIN_SEARCH};
          key_nx   = '0;
          vkf_nx   = 1'b0;
          ledr_nx  = LEDR_IDLE;
          abort_nx = 1'b0;
        end else begin
          state_nx = state;
        end
      end
      DISPATCH: begin
        if (any_found) begin
          state_nx = FOUND;
          key_nx   = found_key;
          vkf_nx   = 1'b1;
          ledr_nx  = LEDR_FOUND;
          abort_nx = 1'b1;
        end else if (exhausted) begin
          state_nx = DRAIN;
        end else if (|arb_grant) begin
          issue         = 1'b1;
          grant_nx      = arb_grant;
          chunk_base_nx = {1'b0, next_base};
          chunk_last_nx = clip_last(next_base, CHUNK_SIZE, END_SEARCH);
          base_nx       = next_base + {1'b0, CHUNK_SIZE};
        end else begin
          state_nx = DISPATCH;
        end
      end
      DRAIN: begin
        if (any_found) begin
          state_nx = FOUND;
          key_nx   = found_key;
          vkf_nx   = 1'b1;
          ledr_nx  = LEDR_FOUND;
          abort_nx = 1'b1;
        end else if (&arb_req) begin
          state_nx = FAIL;
          key_nx   = '0;
          vkf_nx   = 1'b0;
          ledr_nx  = LEDR_FAIL;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, search pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      next_base       <= {1'b0, BEGIN_SEARCH};
      Core_Grant      <= '0;
      Chunk_Base      <= '0;
      Chunk_Last      <= '0;
      Core_Abort      <= 1'b0;
      Secret_Key      <= '0;
      Valid_Key_Found <= 1'b0;
      LEDR            <= LEDR_IDLE;
    end else begin
      state           <= state_nx;
      next_base       <= base_nx;
      Core_Grant      <= grant_nx;
      Chunk_Base      <= chunk_base_nx;
      Chunk_Last      <= chunk_last_nx;
      Core_Abort      <= abort_nx;
      Secret_Key      <= key_nx;
      Valid_Key_Found <= vkf_nx;
      LEDR            <= ledr_nx;
    end
  end

endmodule

// File: tb/tb_crack_core_scheduler.sv
// Scoreboard bench: expected chunks are queued on start, a negedge monitor checks every grant.
module tb_crack_core_scheduler;

  localparam int NC = 2;
  localparam int B0 = 0;
  localparam int E0 = 9;
  localparam int C0 = 4;

  typedef struct packed {
    logic [23:0] base;
    logic [23:0] last;
  } chunk_t;

  logic          clk, rst, Crack_Start;
  logic [NC-1:0] Core_Req, Core_Found, Core_Grant;
  logic [47:0]   Core_Key;
  logic [23:0]   Chunk_Base, Chunk_Last, Secret_Key;
  logic          Core_Abort, Valid_Key_Found;
  logic [1:0]    LEDR;

  logic          start2, abort2, vkf2;
  logic [NC-1:0] req2, found2, grant2;
  logic [47:0]   key2;
  logic [23:0]   base2, last2, sk2;
  logic [1:0]    ledr2;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     grant_cnt = 0;
  chunk_t exp_q[$];

  crack_core_scheduler #(
    .NUM_CORES(NC), .BEGIN_SEARCH(22'd0), .END_SEARCH(22'd9), .CHUNK_SIZE(22'd4)
  ) dut (
    .clk(clk), .rst(rst), .Crack_Start(Crack_Start), .Core_Req(Core_Req),
    .Core_Found(Core_Found), .Core_Key(Core_Key), .Core_Grant(Core_Grant),
    .Chunk_Base(Chunk_Base), .Chunk_Last(Chunk_Last), .Core_Abort(Core_Abort),
    .Secret_Key(Secret_Key), .Valid_Key_Found(Valid_Key_Found), .LEDR(LEDR)
  );

  crack_core_scheduler #(
    .NUM_CORES(NC), .BEGIN_SEARCH(22'h3FFFFF), .END_SEARCH(22'h3FFFFF), .CHUNK_SIZE(22'd4)
  ) dut_top (
    .clk(clk), .rst(rst), .Crack_Start(start2), .Core_Req(req2),
    .Core_Found(found2), .Core_Key(key2), .Core_Grant(grant2),
    .Chunk_Base(base2), .Chunk_Last(last2), .Core_Abort(abort2),
    .Secret_Key(sk2), .Valid_Key_Found(vkf2), .LEDR(ledr2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Whole search space as a list of chunks, built from plain integer arithmetic.
  task automatic push_chunks();
    for (int b = B0; b <= E0; b += C0) begin
      chunk_t c;
      c.base = 24'(b);
      c.last = 24'((b + C0 - 1 > E0) ? E0 : b + C0 - 1);
      exp_q.push_back(c);
    end
  endtask

  function automatic int rr_pick(input logic [NC-1:0] el, input int last);
    for (int k = 1; k <= NC; k++) begin
      if (el[(last + k) % NC]) return (last + k) % NC;
    end
    return -1;
  endfunction

  // Core models plus grant monitor, all on the falling edge.
  initial begin
    int              busy [NC];
    int              last_core;
    int              pick;
    logic [NC-1:0]   elig;
    logic [NC-1:0]   exp_vec;
    chunk_t          e;
    Core_Req  = '1;
    elig      = '0;
    last_core = NC - 1;
    for (int i = 0; i < NC; i++) busy[i] = 0;
    forever begin
      @(negedge clk);
      if (Core_Grant != '0) begin
        grant_cnt++;
        pick    = rr_pick(elig, last_core);
        exp_vec = (pick < 0) ? '0 : (NC'(1) << pick);
        check("grant_core", 48'(Core_Grant), 48'(exp_vec));
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 48'(Core_Grant), 48'd0);
        end else begin
          e = exp_q.pop_front();
          check("chunk_base", 48'(Chunk_Base), 48'(e.base));
          check("chunk_last", 48'(Chunk_Last), 48'(e.last));
        end
        last_core = Core_Grant[1] ? 1 : 0;
      end else begin
        check("chunk_zero_when_idle", {Chunk_Base, Chunk_Last}, 48'd0);
      end
      if (rst) last_core = NC - 1;
      for (int i = 0; i < NC; i++) begin
        if (rst || Core_Abort) begin
          Core_Req[i] = 1'b1;
          busy[i] = 0;
        end else if (Core_Grant[i]) begin
          Core_Req[i] = 1'b0;
          busy[i] = $urandom_range(1, 5);
        end else if (busy[i] != 0) begin
          busy[i]--;
          if (busy[i] == 0) Core_Req[i] = 1'b1;
        end
      end
      elig = Core_Req & ~Core_Grant;
    end
  end

  task automatic start_search();
    @(posedge clk); #1 Crack_Start = 1'b1;
    push_chunks();
    @(posedge clk); #1 Crack_Start = 1'b0;
  endtask

  task automatic wait_ledr(input logic [1:0] v, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #1;
      if (LEDR === v) ok = 1'b1;
    end
    check(name, 48'(LEDR), 48'(v));
  endtask

  task automatic wait_grant(input int g0, input string name);
    for (int i = 0; i < 100 && grant_cnt == g0; i++) begin
      @(posedge clk); #1;
    end
    check(name, 48'(grant_cnt > g0), 48'd1);
  endtask

  task automatic pulse_found(input logic [NC-1:0] f, input logic [47:0] k);
    @(posedge clk); #1 Core_Found = f; Core_Key = k;
    @(posedge clk); #1 Core_Found = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, g1;
    rst = 1'b1; Crack_Start = 1'b0; Core_Found = '0; Core_Key = '0;
    start2 = 1'b0; req2 = 2'b01; found2 = '0; key2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_grant", 48'(Core_Grant), 48'd0);
    check("rst_outputs", {Secret_Key, 20'd0, Core_Abort, Valid_Key_Found, LEDR}, 48'd0);

    // Full search with no key: three chunks, last one clipped, then FAIL.
    g0 = grant_cnt;
    start_search();
    wait_ledr(2'b10, "t1_fail_ledr");
    check("t1_grant_count", 48'(grant_cnt - g0), 48'd3);
    check("t1_all_chunks_sent", 48'(exp_q.size()), 48'd0);
    check("t1_fail_key_vkf", {Secret_Key, 23'd0, Valid_Key_Found}, 48'd0);

    // Core1 reports key 6 during the search.
    g0 = grant_cnt;
    start_search();
    wait_grant(g0, "t2_first_grant");
    pulse_found(2'b10, {24'h000006, 24'h0});
    exp_q.delete();
    check("t2_secret", 48'(Secret_Key), 48'h6);
    check("t2_vkf_abort_ledr", 48'({Valid_Key_Found, Core_Abort, LEDR}), 48'({2'b11, 2'b01}));
    g1 = grant_cnt;
    repeat (10) @(posedge clk);
    #1 check("t2_no_grant_after_found", 48'(grant_cnt), 48'(g1));
    check("t2_abort_held", 48'(Core_Abort), 48'd1);

    // Found while already FOUND is ignored; start clears; start while searching is ignored.
    pulse_found(2'b01, {24'h0, 24'h000009});
    check("t4_found_ignored", 48'(Secret_Key), 48'h6);
    g0 = grant_cnt;
    start_search();
    check("t4_cleared", {Secret_Key, 20'd0, Core_Abort, Valid_Key_Found, LEDR}, 48'd0);
    wait_grant(g0, "t4_first_grant");
    @(posedge clk); #1 Crack_Start = 1'b1;
    @(posedge clk); #1 Crack_Start = 1'b0;
    wait_ledr(2'b10, "t4_fail_ledr");
    check("t4_all_chunks_sent", 48'(exp_q.size()), 48'd0);
    check("t4_grant_count", 48'(grant_cnt - g0), 48'd3);

    // Both cores found on the very first dispatch cycle: lowest index wins, no grant.
    @(posedge clk); #1 Crack_Start = 1'b1;
    @(posedge clk); #1 Crack_Start = 1'b0; Core_Found = 2'b11; Core_Key = {24'd5, 24'd2};
    g0 = grant_cnt;
    @(posedge clk); #1 Core_Found = '0;
    check("t3_no_grant_on_found", 48'(Core_Grant), 48'd0);
    check("t3_secret_lowest", 48'(Secret_Key), 48'h2);
    check("t3_ledr", 48'(LEDR), 48'h1);
    repeat (5) @(posedge clk);
    #1 check("t3_no_later_grant", 48'(grant_cnt), 48'(g0));

    // Reset in the middle of a search, then restart from the beginning.
    g0 = grant_cnt;
    start_search();
    wait_grant(g0, "t5_first_grant");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    check("t5_rst_grant", 48'(Core_Grant), 48'd0);
    check("t5_rst_chunk", {Chunk_Base, Chunk_Last}, 48'd0);
    check("t5_rst_outputs", {Secret_Key, 20'd0, Core_Abort, Valid_Key_Found, LEDR}, 48'd0);
    g1 = grant_cnt;
    repeat (5) @(posedge clk);
    #1 check("t5_idle_no_grant", 48'(grant_cnt), 48'(g1));
    start_search();
    wait_ledr(2'b10, "t5_restart_fail");
    check("t5_all_chunks_sent", 48'(exp_q.size()), 48'd0);

    // Single-key space at the very top: one grant, no wrap back to zero.
    begin
      int          n2 = 0;
      logic [23:0] b2 = '0, l2 = '0;
      bit          ok = 1'b0;
      @(posedge clk); #1 start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (grant2 != '0) begin
          n2++; b2 = base2; l2 = last2;
        end
      end
      check("t6_grant_count", 48'(n2), 48'd1);
      check("t6_base", 48'(b2), 48'h3FFFFF);
      check("t6_last", 48'(l2), 48'h3FFFFF);
      check("t6_drain_ledr", 48'(ledr2), 48'd0);
      req2 = 2'b11;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(posedge clk); #1;
        if (ledr2 === 2'b10) ok = 1'b1;
      end
      check("t6_fail_ledr", 48'(ledr2), 48'h2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
